// File: rtl/prio_dec_pkg.sv
// Shared types for the sequential priority decoder: FSM states, buffered beat layout
// and the default widths that the top level derives from them.
package prio_dec_pkg;

  localparam int unsigned DefNOut  = 8;
  localparam int unsigned DefCodeW = $clog2(DefNOut);
  localparam int unsigned EntryW   = DefCodeW + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StWait = 2'd2
  } state_e;

  typedef struct packed {
    logic [DefCodeW-1:0] code;
    logic                nv;
  } entry_t;

endpackage

// File: rtl/prio_dec_fifo.sv
// Small synchronous FIFO with a registered occupancy count; Depth must be a power of 2.
module prio_dec_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push, do_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  assign do_push = push && (count_q != (PtrW+1)'(Depth));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (PtrW+1)'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/priority_decoder_seq.sv
// Receive end of the priority encoder link: buffers {code, nv} beats and presents each as
// a registered one-hot word for at least HOLD_CYCLES cycles before a downstream release.
module priority_decoder_seq
  import prio_dec_pkg::*;
#(
  parameter int unsigned N_OUT       = DefNOut,
  parameter int unsigned CODE_W      = DefCodeW,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_nv,
  output logic [N_OUT-1:0]  d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              nv_out,
  output logic              busy,
  output logic              err
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N_OUT-1:0]   d_q, d_d;
  logic               valid_q, valid_d;
  logic               nv_q, nv_d;
  logic               err_q, err_d;

  entry_t             wr_entry, head;
  logic [EntryW-1:0]  fifo_rdata;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign wr_entry.code = in_code;
  assign wr_entry.nv   = in_nv;
  assign head          = entry_t'(fifo_rdata);

  prio_dec_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .wdata (EntryW'(wr_entry)),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Only the registered count gates input; a same-cycle pop never frees a slot.
  assign in_ready = !fifo_full;

  always_comb begin
    logic load, retire;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    d_d        = d_q;
    valid_d    = valid_q;
    nv_d       = nv_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    retire     = 1'b0;

    unique case (state_q)
      StIdle: load = !fifo_empty;
      StHold: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else if (out_ready) begin
          retire = 1'b1;
        end else begin
          state_d = StWait;
        end
      end
      StWait: retire = out_ready;
      default: state_d = StIdle;
    endcase

    if (retire) begin
      if (!fifo_empty) begin
        load = 1'b1;
      end else begin
        d_d     = '0;
        valid_d = 1'b0;
        nv_d    = 1'b0;
        state_d = StIdle;
      end
    end

    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = StHold;
      hold_cnt_d = HoldW'(HOLD_CYCLES - 1);
      valid_d    = 1'b1;
      nv_d       = head.nv;
      d_d        = '0;
      if (!head.nv) begin
        for (int unsigned i = 0; i < N_OUT; i++) begin
          d_d[i] = (head.code == CODE_W'(i));
        end
        // Out-of-range codes still occupy a hold slot, just with an all-zero word.
        if (32'(head.code) >= N_OUT) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      d_q        <= '0;
      valid_q    <= 1'b0;
      nv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      d_q        <= d_d;
      valid_q    <= valid_d;
      nv_q       <= nv_d;
      err_q      <= err_d;
    end
  end

  assign d         = d_q;
  assign out_valid = valid_q;
  assign nv_out    = nv_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed bench for priority_decoder_seq: default 8-line instance plus a 6-line instance
// for the out-of-range code path.
module tb_priority_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_nv, out_ready;
  logic [2:0] in_code;
  logic       in_ready, out_valid, nv_out, busy, err;
  logic [7:0] d;

  logic       v6, nv6, ready6;
  logic [2:0] code6;
  logic       in_ready6, out_valid6, nv_out6, busy6, err6;
  logic [5:0] d6;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  priority_decoder_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_nv     (in_nv),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .nv_out    (nv_out),
    .busy      (busy),
    .err       (err)
  );

  priority_decoder_seq #(
    .N_OUT  (6),
    .CODE_W (3)
  ) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v6),
    .in_ready  (in_ready6),
    .in_code   (code6),
    .in_nv     (nv6),
    .d         (d6),
    .out_valid (out_valid6),
    .out_ready (ready6),
    .nv_out    (nv_out6),
    .busy      (busy6),
    .err       (err6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_nv = 1'b0; in_code = 3'd0; out_ready = 1'b0;
    v6 = 1'b0; nv6 = 1'b0; code6 = 3'd0; ready6 = 1'b0;

    // Reset then idle
    tick(); tick();
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_nv", 32'(nv_out), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Single beat, code 5, held exactly 4 cycles
    out_ready = 1'b1; in_valid = 1'b1; in_code = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("single_latency_valid", 32'(out_valid), 32'h0);
    chk("single_busy", 32'(busy), 32'h1);
    tick();
    chk("single_d_c1", 32'(d), 32'h20);
    chk("single_valid_c1", 32'(out_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_d_hold", 32'(d), 32'h20);
    end
    tick();
    chk("single_d_retired", 32'(d), 32'h0);
    chk("single_valid_retired", 32'(out_valid), 32'h0);
    chk("single_busy_done", 32'(busy), 32'h0);

    // Back-to-back 0,3,7 with stall; FIFO fills
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd0;
    tick();
    in_code = 3'd3;
    tick();
    chk("b2b_d0", 32'(d), 32'h01);
    in_code = 3'd7;
    tick();
    in_valid = 1'b0;
    chk("b2b_full_in_ready", 32'(in_ready), 32'h0);
    repeat (4) tick();
    chk("b2b_wait_d", 32'(d), 32'h01);
    chk("b2b_wait_valid", 32'(out_valid), 32'h1);
    chk("b2b_wait_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    tick();
    chk("b2b_d3", 32'(d), 32'h08);
    chk("b2b_d3_valid", 32'(out_valid), 32'h1);
    chk("b2b_in_ready_freed", 32'(in_ready), 32'h1);
    repeat (3) tick();
    chk("b2b_d3_hold", 32'(d), 32'h08);
    tick();
    chk("b2b_d7", 32'(d), 32'h80);
    chk("b2b_d7_valid", 32'(out_valid), 32'h1);
    repeat (4) tick();
    chk("b2b_drained_d", 32'(d), 32'h0);
    chk("b2b_drained_valid", 32'(out_valid), 32'h0);

    // No-valid beat: nv=1 with code 6
    in_valid = 1'b1; in_nv = 1'b1; in_code = 3'd6;
    tick();
    in_valid = 1'b0; in_nv = 1'b0;
    tick();
    chk("nv_d", 32'(d), 32'h0);
    chk("nv_flag", 32'(nv_out), 32'h1);
    chk("nv_valid", 32'(out_valid), 32'h1);
    repeat (3) tick();
    chk("nv_flag_hold", 32'(nv_out), 32'h1);
    tick();
    chk("nv_flag_retired", 32'(nv_out), 32'h0);
    chk("nv_valid_retired", 32'(out_valid), 32'h0);
    chk("nv_err", 32'(err), 32'h0);

    // Reset mid-HOLD with one beat buffered
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd2;
    tick();
    in_code = 3'd4;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("midrst_d_before", 32'(d), 32'h04);
    chk("midrst_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("midrst_d", 32'(d), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(); tick();
    chk("midrst_no_stale_valid", 32'(out_valid), 32'h0);
    chk("midrst_no_stale_d", 32'(d), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h1);

    // N_OUT=6 instance: out-of-range code sets sticky err
    ready6 = 1'b1; v6 = 1'b1; code6 = 3'd7;
    tick();
    v6 = 1'b0;
    tick();
    chk("n6_bad_d", 32'(d6), 32'h0);
    chk("n6_bad_valid", 32'(out_valid6), 32'h1);
    chk("n6_bad_err", 32'(err6), 32'h1);
    repeat (4) tick();
    chk("n6_bad_retired", 32'(out_valid6), 32'h0);
    chk("n6_err_sticky", 32'(err6), 32'h1);
    v6 = 1'b1; code6 = 3'd1;
    tick();
    v6 = 1'b0;
    tick();
    chk("n6_code1_d", 32'(d6), 32'h02);
    chk("n6_err_still", 32'(err6), 32'h1);
    chk("n6_nv", 32'(nv_out6), 32'h0);
    chk("main_err_clear", 32'(err), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
